// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: widths, opcodes and FSM states.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// Bundle of the two requester ports, the response port and status outputs.
// The master side issues operations and consumes results; the slave side is
// the scheduler itself.
interface alu_sched_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_cout;
  logic              rsp_zero;

  logic              busy;
  logic [CNT_W-1:0]  done_cnt;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_zero,
    input  busy, done_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_zero,
    output busy, done_cnt
  );

endinterface

// File: rtl/alu_sched_alu.sv
// Purely combinational 4-bit ALU. Cout is the carry for ADD, the borrow for
// SUB, and the bit shifted out for SHL/SHR; it is 0 for the logic ops.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] Y,
  output logic              Cout,
  output logic              Zero
);

  logic [DATA_W:0] wide;

  // Compute a one-bit-wider result so the extra MSB carries Cout for every op.
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, A} + {1'b0, B};
      OP_SUB:  wide = {1'b0, A} - {1'b0, B};
      OP_AND:  wide = {1'b0, A & B};
      OP_OR:   wide = {1'b0, A | B};
      OP_XOR:  wide = {1'b0, A ^ B};
      OP_NOT:  wide = {1'b0, ~A};
      OP_SHL:  wide = {A, 1'b0};
      OP_SHR:  wide = {A[0], 1'b0, A[DATA_W-1:1]};
      default: wide = '0;
    endcase
  end

  assign Y    = wide[DATA_W-1:0];
  assign Cout = wide[DATA_W];
  assign Zero = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin front end for a single shared ALU. One operation
// is in flight at a time: IDLE grants and latches, EXEC registers the ALU
// result, RESP holds it until the consumer takes it.
module alu_sched
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  bus
);

  state_t            state;
  logic              last_grant;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q;

  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_y_q;
  logic              rsp_cout_q;
  logic              rsp_zero_q;
  logic              busy_q;
  logic [CNT_W-1:0]  done_q;

  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] alu_y;
  logic              alu_cout;
  logic              alu_zero;

  // Round-robin pick: requester 1 wins only if it is alone or requester 0 was served last.
  always_comb begin
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    grant0 = bus.req0_valid && !grant1;
  end

  assign bus.req0_ready = rst_n && (state == IDLE) && grant0;
  assign bus.req1_ready = rst_n && (state == IDLE) && grant1;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = busy_q;
  assign bus.done_cnt   = done_q;

  alu u_alu (
    .A    (a_q),
    .B    (b_q),
    .op   (op_q),
    .Y    (alu_y),
    .Cout (alu_cout),
    .Zero (alu_zero)
  );

  // Scheduler FSM with all response/status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q        <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q        <= grant1 ? bus.req1_b  : bus.req0_b;
            op_q       <= grant1 ? bus.req1_op : bus.req0_op;
            id_q       <= grant1;
            last_grant <= grant1;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_cout_q  <= alu_cout;
          rsp_zero_q  <= alu_zero;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= done_q + 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a scoreboard of expected responses.
module tb_alu_sched;
  import alu_pkg::*;

  typedef struct {
    logic       id;
    logic [3:0] y;
    logic       cout;
    logic       zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nAsserts;
  int   nFail;
  logic [7:0] expDone;
  exp_t sb[$];

  alu_sched_if bus ();

  alu_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Reference ALU behaviour written with integer arithmetic.
  function automatic exp_t model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op);
    exp_t m;
    int ia;
    int ib;
    int r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 15); end
      3'd1: begin c = (ia < ib); r = ia - ib + 16; end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - ia;
      3'd6: begin r = ia * 2; c = (ia >= 8); end
      default: begin r = ia / 2; c = (ia % 2) == 1; end
    endcase
    r      = r % 16;
    m.id   = id;
    m.y    = 4'(r);
    m.cout = c;
    m.zero = (r == 0);
    return m;
  endfunction

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic checkRsp(input string tag, input exp_t e);
    checkOutput({tag, "_id"},   32'(bus.rsp_id),   32'(e.id));
    checkOutput({tag, "_y"},    32'(bus.rsp_y),    32'(e.y));
    checkOutput({tag, "_cout"}, 32'(bus.rsp_cout), 32'(e.cout));
    checkOutput({tag, "_zero"}, 32'(bus.rsp_zero), 32'(e.zero));
  endtask

  // One complete operation from an IDLE start (entered just after a rising edge).
  task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input int stall);
    exp_t e;
    int lat;
    drive(id, 1'b1, a, b, op);
    bus.rsp_ready = (stall == 0);
    @(negedge clk);
    checkOutput("grant_ready", 32'(id ? bus.req1_ready : bus.req0_ready), 1);
    checkOutput("other_ready", 32'(id ? bus.req0_ready : bus.req1_ready), 0);
    checkOutput("idle_busy", 32'(bus.busy), 0);
    sb.push_back(model(id, a, b, op));
    @(posedge clk); #1;
    drive(id, 1'b0, 4'd9, ~b, ~op);
    @(negedge clk);
    checkOutput("exec_busy", 32'(bus.busy), 1);
    checkOutput("exec_rsp_valid", 32'(bus.rsp_valid), 0);
    lat = 1;
    while (!bus.rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 2);
    if (bus.rsp_valid) begin
      for (int i = 0; i < stall; i++) begin
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checkOutput("stall_valid", 32'(bus.rsp_valid), 1);
        checkOutput("stall_ready0", 32'(bus.req0_ready), 0);
        checkOutput("stall_ready1", 32'(bus.req1_ready), 0);
        checkRsp("stall", sb[0]);
        @(negedge clk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      #1;
      e = sb.pop_front();
      checkRsp("rsp", e);
      expDone = expDone + 8'd1;
      @(posedge clk); #1;
      checkOutput("post_rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("post_busy", 32'(bus.busy), 0);
      checkOutput("done_cnt", 32'(bus.done_cnt), 32'(expDone));
    end else begin
      sb.delete();
      @(posedge clk); #1;
    end
  endtask

  // Directed sequence: reset, contention, single ops, backpressure, reset mid-op, counter wrap.
  initial begin
    exp_t e;
    logic expGrant;
    int grants;

    clk = 1'b0;
    rst_n = 1'b0;
    nAsserts = 0;
    nFail = 0;
    expDone = 8'd0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 4'd1, 4'd2, OP_ADD);
    drive(1'b1, 1'b1, 4'd12, 4'd5, OP_SUB);

    repeat (3) @(negedge clk);
    checkOutput("rst_ready0", 32'(bus.req0_ready), 0);
    checkOutput("rst_ready1", 32'(bus.req1_ready), 0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("rst_rsp_id", 32'(bus.rsp_id), 0);
    checkOutput("rst_rsp_y", 32'(bus.rsp_y), 0);
    checkOutput("rst_rsp_cout", 32'(bus.rsp_cout), 0);
    checkOutput("rst_rsp_zero", 32'(bus.rsp_zero), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_done_cnt", 32'(bus.done_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    $display("[TB] contention phase");
    expGrant = 1'b0;
    grants = 0;
    for (int cyc = 0; cyc < 40 && (grants < 4 || sb.size() > 0); cyc++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        checkOutput("rr_grant", 32'({bus.req1_ready, bus.req0_ready}),
                    expGrant ? 32'd2 : 32'd1);
        sb.push_back(expGrant ? model(1'b1, 4'd12, 4'd5, OP_SUB) : model(1'b0, 4'd1, 4'd2, OP_ADD));
        expGrant = ~expGrant;
        grants++;
      end
      if (bus.rsp_valid) begin
        checkOutput("rr_sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkRsp("rr_rsp", e);
          expDone = expDone + 8'd1;
        end
      end
      @(posedge clk); #1;
      if (grants == 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checkOutput("rr_grants", 32'(grants), 4);
    checkOutput("rr_sb_empty", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rr_done_cnt", 32'(bus.done_cnt), 32'(expDone));

    $display("[TB] directed single operations");
    applyStimulus(1'b0, 4'd2, 4'd5, OP_ADD, 0);
    applyStimulus(1'b1, 4'd15, 4'd1, OP_ADD, 5);
    applyStimulus(1'b0, 4'd3, 4'd3, OP_SUB, 0);
    for (int op = 0; op < 8; op++) begin
      applyStimulus(1'(op % 2), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'(op), op % 3);
    end

    $display("[TB] reset during EXEC");
    drive(1'b0, 1'b1, 4'd6, 4'd7, OP_XOR);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req1_valid = 1'b1;
    #1;
    checkOutput("rst_mid_ready0", 32'(bus.req0_ready), 0);
    checkOutput("rst_mid_ready1", 32'(bus.req1_ready), 0);
    @(posedge clk); #1;
    checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("rst_mid_busy", 32'(bus.busy), 0);
    checkOutput("rst_mid_done_cnt", 32'(bus.done_cnt), 0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    expDone = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_mid_no_rsp", 32'(bus.rsp_valid), 0);
    end
    @(posedge clk); #1;

    $display("[TB] done counter wrap");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'(i % 2), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 0);
    end
    checkOutput("wrap_done_cnt", 32'(bus.done_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
